i2c_target: RTL and testbench
=============================

// Module: i2c_target
//
// PURPOSE
//  Synthesisable I2C target (slave) that answers one 7-bit address.
//  Oversamples SCL/SDA on the system clock, detects START/STOP/repeated START and ACKs its address.
//  Write direction: delivers received bytes to the fabric. Read direction: serves fabric-supplied bytes.
//  Sits at the bus pins opposite the i2c master; the master is the bench partner in system tests.
//
// PARAMETERS
//  DEVICE_ADDR  7'h50  7-bit address this target responds to
//  SYNC_STAGES  2      synchroniser depth on SCL/SDA inputs (>=2)
//
// PORTS
//  i_Clk        in     1  system clock
//  i_Rst        in     1  asynchronous, active-high reset
//  i_SCL        in     1  bus clock from master (target never drives SCL)
//  io_SDA       inout  1  open-drain data: drive 0 or release to 'z'; pull-up is external
//  i_Tx_Data    in     8  byte to return on reads; sampled when the target loads a read byte
//  o_Tx_Req     out    1  1-cycle pulse: fabric must present the next read byte on i_Tx_Data
//  o_Rx_Data    out    8  last byte written by master; holds until the next o_Rx_Valid
//  o_Rx_Valid   out    1  1-cycle pulse: o_Rx_Data updated
//  o_Busy       out    1  high from an addressed START until STOP/NACK/address mismatch
//  o_Stop       out    1  1-cycle pulse on every STOP seen on the bus
//
// BEHAVIOUR
//  Reset values: SDA released; o_Tx_Req/o_Rx_Valid/o_Busy/o_Stop=0; o_Rx_Data=8'h00; state IDLE.
//  Input path: SYNC_STAGES flops, then one edge-detect register (SCL/SDA event latency = SYNC_STAGES+1 clocks).
//  Master SCL half-period must exceed SYNC_STAGES+2 system clocks (CLK_DIV>=4 with defaults).
//  START/repeated START: synced SDA 1->0 while synced SCL=1; from ANY state -> ADDR, bit count reset.
//  STOP: synced SDA 0->1 while SCL=1; from any state -> IDLE, release SDA, pulse o_Stop, o_Busy=0.
//  Bit sampling: SDA on SCL rising edge. SDA drive changes: only on SCL falling edge.
//  States:
//   IDLE     : wait for START.
//   ADDR     : shift 8 bits MSB first.
//              On 8th rise: {addr,rw} matches -> ADDR_ACK; mismatch -> WAIT_STOP.
//              If match with rw=1, pulse o_Tx_Req.
//   ADDR_ACK : on falling edge entering ACK slot, drive SDA low; o_Busy=1.
//              On following fall, release SDA. rw=0 -> WR_DATA. rw=1 -> load i_Tx_Data, drive bit7, RD_DATA.
//   WR_DATA  : shift 8 bits; on 8th rise, o_Rx_Data<=byte, pulse o_Rx_Valid -> WR_ACK.
//   WR_ACK   : drive ACK for slot 9; release on its falling edge -> WR_DATA (multi-byte write).
//   RD_DATA  : present bit on each fall; release SDA on fall after bit0 -> RD_ACK.
//   RD_ACK   : sample master bit on rise.
//              0 (ACK): pulse o_Tx_Req; load i_Tx_Data on next fall -> RD_DATA.
//              1 (NACK): -> WAIT_STOP, o_Busy=0.
//   WAIT_STOP: SDA released; only START or STOP leave.
//  Fabric has >= one SCL half-period between o_Tx_Req and the i_Tx_Data sample.
//  No clock stretching; the target never holds SCL.
//  Simultaneous START and bit-edge detect in one cycle: START wins.
//  Reset mid-transaction: SDA released combinationally on i_Rst, all state cleared.
//  Master then sees NACK or 8'hFF.
//
// CONFIGURATION
//  I2C_TARGET_GCALL_EN defined: address byte 8'h00 (general call, write) is also ACKed.
//   Following bytes are delivered on o_Rx_Data/o_Rx_Valid with o_Gcall=1.
//   o_Gcall (out, 1) exists only when the macro is defined; it holds from address match to STOP.
//   General call with rw=1 -> WAIT_STOP, no ACK.
//  Not defined: 8'h00 is treated as an ordinary mismatch (NACK); no o_Gcall port.
//
// STRUCTURE
//  Package i2c_pkg: state enum i2c_tgt_state_t, ACK/NACK constants, GCALL_ADDR=7'h00.
//  Sub-module i2c_bus_sync: synchroniser + edge detect.
//   Outputs scl_rise, scl_fall, start_det, stop_det, sda_s.
//  Top holds the FSM, the shift register and the 3-bit bit counter.
//
// TESTING
//  1 Master write addr 0x50, data 0xA5 -> ACK on both bytes; o_Rx_Valid once with o_Rx_Data=0xA5; o_Stop pulses.
//  2 Master read addr 0x50, i_Tx_Data=0x3C -> o_Tx_Req once; master o_Data=0x3C, no ack error; target releases after NACK.
//  3 Write to addr 0x51 -> SDA never driven by target; master reports ack error; o_Rx_Valid, o_Busy stay 0.
//  4 Bit-bang write 0x50: bytes 0x11, 0x22; repeated START; read 2 bytes (i_Tx_Data 0x80 then 0x7F) with ACK then NACK
//    -> two o_Rx_Valid (0x11, 0x22); two o_Tx_Req; bytes 0x80, 0x7F seen on SDA.
//  5 Assert i_Rst during 4th bit of a write data byte -> SDA released next cycle; no o_Rx_Valid; next full write of 0xA5 succeeds.
//  6 GCALL_EN: write to 0x00 with data 0x06 -> ACK, o_Rx_Data=0x06, o_Gcall=1; without macro -> NACK.

Source files
------------

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encoding and bus constants for the I2C target
package i2c_pkg;
   typedef enum logic [2:0] {
      IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
   } i2c_tgt_state_t;
   localparam logic ACK = 1'b0;
   localparam logic NACK = 1'b1;
   localparam logic [6:0] GCALL_ADDR = 7'h00;
endpackage

// File: rtl/i2c_bus_sync.sv
// i2c_bus_sync: synchronises SCL/SDA and flags clock edges plus START/STOP conditions
module i2c_bus_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic i_Clk,
   input  logic i_Rst,
   input  logic i_SCL,
   input  logic i_SDA,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det,
   output logic sda_s
);
   logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
   logic scl_prev_q, sda_prev_q, scl_s;
   assign scl_s = scl_sync_q[SYNC_STAGES-1];
   assign sda_s = sda_sync_q[SYNC_STAGES-1];
   // shift raw pins into the synchroniser chains
   always_comb begin
      scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], i_SCL};
      sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], i_SDA};
   end
   // chains and edge-detect history reset to the idle (released) bus level
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
      end else begin
         scl_sync_q <= scl_sync_d;
         sda_sync_q <= sda_sync_d;
         scl_prev_q <= scl_s;
         sda_prev_q <= sda_s;
      end
   end
   assign scl_rise  = scl_s & ~scl_prev_q;
   assign scl_fall  = ~scl_s & scl_prev_q;
   assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
   assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
endmodule

// File: rtl/i2c_target.sv
// i2c_target: 7-bit address I2C target with byte-wide fabric interface (general call via I2C_TARGET_GCALL_EN)
module i2c_target
   import i2c_pkg::*;
#(
   parameter logic [6:0] DEVICE_ADDR = 7'h50,
   parameter int SYNC_STAGES = 2
) (
   input  logic       i_Clk,
   input  logic       i_Rst,
   input  logic       i_SCL,
   inout  wire        io_SDA,
   input  logic [7:0] i_Tx_Data,
   output logic       o_Tx_Req,
   output logic [7:0] o_Rx_Data,
   output logic       o_Rx_Valid,
   output logic       o_Busy,
   output logic       o_Stop
`ifdef I2C_TARGET_GCALL_EN
   ,
   output logic       o_Gcall
`endif
);
   i2c_tgt_state_t state_q, state_d;
   logic [7:0] shift_q, shift_d, rx_data_q, rx_data_d, byte_in;
   logic [2:0] cnt_q, cnt_d;
   logic oe_q, oe_d, rx_valid_q, rx_valid_d, tx_req_q, tx_req_d;
   logic busy_q, busy_d, stop_q, stop_d;
   logic scl_rise, scl_fall, start_det, stop_det, sda_s;
   logic adr_hit, gc_hit, match;
   i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .i_Clk(i_Clk), .i_Rst(i_Rst), .i_SCL(i_SCL), .i_SDA(io_SDA),
      .scl_rise(scl_rise), .scl_fall(scl_fall),
      .start_det(start_det), .stop_det(stop_det), .sda_s(sda_s)
   );
   assign byte_in = {shift_q[6:0], sda_s};
   assign adr_hit = byte_in[7:1] == DEVICE_ADDR;
   assign match   = adr_hit | gc_hit;
`ifdef I2C_TARGET_GCALL_EN
   logic gcall_q, gcall_d;
   assign gc_hit = byte_in == {GCALL_ADDR, 1'b0};
   // general-call flag latches at the address decision and clears on STOP
   always_comb gcall_d = start_det ? gcall_q : stop_det ? 1'b0 :
      (state_q == ADDR && scl_rise && cnt_q == 3'd7) ? gc_hit : gcall_q;
   // general-call flag register
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) gcall_q <= 1'b0;
      else gcall_q <= gcall_d;
   end
   assign o_Gcall = gcall_q;
`else
   assign gc_hit = 1'b0;
`endif
   // bus protocol FSM: START/STOP override everything, otherwise act on SCL edges
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_d = cnt_q;
      oe_d = oe_q;
      rx_data_d = rx_data_q;
      rx_valid_d = 1'b0;
      tx_req_d = 1'b0;
      busy_d = busy_q;
      stop_d = 1'b0;
      if (start_det) begin
         state_d = ADDR;
         cnt_d = 3'd0;
         oe_d = 1'b0;
      end else if (stop_det) begin
         state_d = IDLE;
         oe_d = 1'b0;
         stop_d = 1'b1;
         busy_d = 1'b0;
      end else begin
         case (state_q)
            ADDR, WR_DATA: if (scl_rise) begin
               shift_d = byte_in;
               cnt_d = cnt_q + 3'd1;
               if (cnt_q == 3'd7 && state_q == ADDR) begin
                  state_d = match ? ADDR_ACK : WAIT_STOP;
                  busy_d = match;
                  tx_req_d = match & byte_in[0];
               end else if (cnt_q == 3'd7) begin
                  rx_data_d = byte_in;
                  rx_valid_d = 1'b1;
                  state_d = WR_ACK;
               end
            end
            ADDR_ACK: if (scl_fall) begin
               // oe_q distinguishes the fall entering the ACK slot from the one leaving it
               if (!oe_q) oe_d = 1'b1;
               else if (shift_q[0]) begin
                  shift_d = i_Tx_Data;
                  oe_d = ~i_Tx_Data[7];
                  state_d = RD_DATA;
               end else begin
                  oe_d = 1'b0;
                  state_d = WR_DATA;
               end
            end
            WR_ACK: if (scl_fall) begin
               oe_d = ~oe_q;
               state_d = oe_q ? WR_DATA : WR_ACK;
            end
            RD_DATA: if (scl_rise) cnt_d = cnt_q + 3'd1;
               else if (scl_fall) begin
                  // cnt_q counts bits already clocked; zero after the eighth means byte done
                  oe_d = (cnt_q != 3'd0) & ~shift_q[~cnt_q];
                  state_d = (cnt_q == 3'd0) ? RD_ACK : RD_DATA;
               end
            RD_ACK: if (scl_rise) begin
               state_d = (sda_s == NACK) ? WAIT_STOP : RD_ACK;
               busy_d = sda_s == ACK;
               tx_req_d = sda_s == ACK;
            end else if (scl_fall) begin
               shift_d = i_Tx_Data;
               oe_d = ~i_Tx_Data[7];
               state_d = RD_DATA;
            end
            default: ;
         endcase
      end
   end
   // protocol state and output registers
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         state_q <= IDLE;
         shift_q <= 8'h00;
         cnt_q <= 3'd0;
         oe_q <= 1'b0;
         rx_data_q <= 8'h00;
         rx_valid_q <= 1'b0;
         tx_req_q <= 1'b0;
         busy_q <= 1'b0;
         stop_q <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q <= cnt_d;
         oe_q <= oe_d;
         rx_data_q <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         tx_req_q <= tx_req_d;
         busy_q <= busy_d;
         stop_q <= stop_d;
      end
   end
   assign io_SDA     = (oe_q && !i_Rst) ? 1'b0 : 1'bz;
   assign o_Tx_Req   = tx_req_q;
   assign o_Rx_Data  = rx_data_q;
   assign o_Rx_Valid = rx_valid_q;
   assign o_Busy     = busy_q;
   assign o_Stop     = stop_q;
endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: bit-banged I2C master against i2c_target with a transaction-level expectation model
module tb_i2c_target;
   localparam int Q = 5;
   logic clk = 1'b0, rst = 1'b1, m_scl = 1'b1, m_sda_oe = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic tx_req, rx_valid, busy, stop_p;
   logic [7:0] rx_data;
   wire sda;
   int vectors = 0, miscompares = 0, n_txreq = 0, n_stop = 0, exp_txreq = 0, exp_stop = 0;
   logic [7:0] exp_rx[$];
   logic [7:0] tx_src[$];
   logic exp_gcall = 1'b0;
   assign sda = m_sda_oe ? 1'b0 : 1'bz;
   pullup (sda);
   always #5 clk = ~clk;
`ifdef I2C_TARGET_GCALL_EN
   logic gcall;
`endif
   i2c_target dut (
      .i_Clk(clk), .i_Rst(rst), .i_SCL(m_scl), .io_SDA(sda), .i_Tx_Data(tx_data),
      .o_Tx_Req(tx_req), .o_Rx_Data(rx_data), .o_Rx_Valid(rx_valid), .o_Busy(busy), .o_Stop(stop_p)
`ifdef I2C_TARGET_GCALL_EN
      , .o_Gcall(gcall)
`endif
   );
   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic clk_bit(input logic b, output logic r);
      wait_clks(Q); m_sda_oe = ~b;
      wait_clks(Q); m_scl = 1'b1;
      wait_clks(Q); r = sda;
      wait_clks(Q); m_scl = 1'b0;
   endtask
   task automatic start_c();
      wait_clks(Q); m_sda_oe = 1'b0;
      wait_clks(Q); m_scl = 1'b1;
      wait_clks(2 * Q); m_sda_oe = 1'b1;
      wait_clks(2 * Q); m_scl = 1'b0;
   endtask
   task automatic stop_c();
      wait_clks(Q); m_sda_oe = 1'b1;
      wait_clks(Q); m_scl = 1'b1;
      wait_clks(2 * Q); m_sda_oe = 1'b0;
      wait_clks(2 * Q);
      exp_stop++;
   endtask
   task automatic write_byte(input logic [7:0] b, output logic ack);
      logic d;
      for (int i = 7; i >= 0; i--) clk_bit(b[i], d);
      clk_bit(1'b1, ack);
   endtask
   task automatic read_byte(input logic nack, output logic [7:0] b);
      logic d;
      for (int i = 7; i >= 0; i--) begin
         clk_bit(1'b1, d);
         b[i] = d;
      end
      clk_bit(nack, d);
   endtask
   task automatic end_checks(input string name);
      wait_clks(4);
      check({name, "_busy_idle"}, {7'd0, busy}, 8'h00);
      check({name, "_stop_count"}, n_stop[7:0], exp_stop[7:0]);
      check({name, "_txreq_count"}, n_txreq[7:0], exp_txreq[7:0]);
      check({name, "_rx_drained"}, exp_rx.size() == 0 ? 8'h01 : 8'h00, 8'h01);
   endtask
   // compare process: every output pulse is matched against the expectation model
   always @(negedge clk) begin
      if (!rst && rx_valid) begin
         if (exp_rx.size() == 0) check("rx_unexpected", rx_data, 8'hxx);
         else check("rx_data", rx_data, exp_rx.pop_front());
`ifdef I2C_TARGET_GCALL_EN
         check("rx_gcall", {7'd0, gcall}, {7'd0, exp_gcall});
`endif
      end
      if (tx_req) n_txreq++;
      if (stop_p) n_stop++;
   end
   // fabric: answer each read request with the next queued byte
   initial forever begin
      @(negedge clk);
      if (tx_req && tx_src.size() > 0) tx_data = tx_src.pop_front();
   end
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
   initial begin
      logic a;
      logic [7:0] rb;
      wait_clks(3);
      check("rst_sda", {7'd0, sda}, 8'h01);
      check("rst_rx_data", rx_data, 8'h00);
      check("rst_flags", {4'd0, tx_req, rx_valid, busy, stop_p}, 8'h00);
      rst = 1'b0;
      wait_clks(5);
      check("idle_flags", {4'd0, tx_req, rx_valid, busy, stop_p}, 8'h00);
      // 1: single-byte write
      start_c();
      write_byte(8'hA0, a); check("t1_addr_ack", {7'd0, a}, 8'h00);
      check("t1_busy", {7'd0, busy}, 8'h01);
      exp_rx.push_back(8'hA5);
      write_byte(8'hA5, a); check("t1_data_ack", {7'd0, a}, 8'h00);
      stop_c();
      check("t1_rx_hold", rx_data, 8'hA5);
      end_checks("t1");
      // 2: single-byte read, master NACKs
      tx_src.push_back(8'h3C); exp_txreq++;
      start_c();
      write_byte(8'hA1, a); check("t2_addr_ack", {7'd0, a}, 8'h00);
      read_byte(1'b1, rb); check("t2_read", rb, 8'h3C);
      wait_clks(2);
      check("t2_released", {7'd0, sda}, 8'h01);
      check("t2_busy_nack", {7'd0, busy}, 8'h00);
      stop_c();
      end_checks("t2");
      // 3: wrong address
      start_c();
      write_byte(8'hA2, a); check("t3_addr_nack", {7'd0, a}, 8'h01);
      check("t3_busy", {7'd0, busy}, 8'h00);
      write_byte(8'h12, a); check("t3_data_nack", {7'd0, a}, 8'h01);
      stop_c();
      end_checks("t3");
      // 4: two-byte write, repeated START, two-byte read
      start_c();
      write_byte(8'hA0, a); check("t4_addr_ack", {7'd0, a}, 8'h00);
      exp_rx.push_back(8'h11); exp_rx.push_back(8'h22);
      write_byte(8'h11, a); check("t4_d0_ack", {7'd0, a}, 8'h00);
      write_byte(8'h22, a); check("t4_d1_ack", {7'd0, a}, 8'h00);
      tx_src.push_back(8'h80); tx_src.push_back(8'h7F); exp_txreq += 2;
      start_c();
      write_byte(8'hA1, a); check("t4_raddr_ack", {7'd0, a}, 8'h00);
      read_byte(1'b0, rb); check("t4_read0", rb, 8'h80);
      read_byte(1'b1, rb); check("t4_read1", rb, 8'h7F);
      stop_c();
      end_checks("t4");
      // 5: reset during 4th bit of a data byte, then a clean write
      start_c();
      write_byte(8'hA0, a); check("t5_addr_ack", {7'd0, a}, 8'h00);
      clk_bit(1'b1, a); clk_bit(1'b0, a); clk_bit(1'b1, a);
      wait_clks(Q); m_sda_oe = 1'b1;
      wait_clks(Q); m_scl = 1'b1;
      wait_clks(Q); rst = 1'b1;
      wait_clks(2);
      check("t5_rst_busy", {7'd0, busy}, 8'h00);
      check("t5_rst_rx_data", rx_data, 8'h00);
      rst = 1'b0;
      wait_clks(Q); m_scl = 1'b0;
      stop_c();
      start_c();
      write_byte(8'hA0, a); check("t5b_addr_ack", {7'd0, a}, 8'h00);
      exp_rx.push_back(8'hA5);
      write_byte(8'hA5, a); check("t5b_data_ack", {7'd0, a}, 8'h00);
      stop_c();
      end_checks("t5");
      // 6: reset while the target holds the ACK low releases SDA at once
      start_c();
      for (int i = 7; i >= 0; i--) begin
         logic [7:0] ad;
         ad = 8'hA0;
         clk_bit(ad[i], a);
      end
      wait_clks(Q); m_sda_oe = 1'b0;
      wait_clks(Q); m_scl = 1'b1;
      wait_clks(Q);
      check("t6_ack_driven", {7'd0, sda}, 8'h00);
      rst = 1'b1;
      #1 check("t6_rst_release", {7'd0, sda}, 8'h01);
      wait_clks(3); rst = 1'b0;
      wait_clks(Q); m_scl = 1'b0;
      stop_c();
      end_checks("t6");
      // 7: general call address
      start_c();
      write_byte(8'h00, a);
`ifdef I2C_TARGET_GCALL_EN
      check("t7_gcall_ack", {7'd0, a}, 8'h00);
      check("t7_gcall_flag", {7'd0, gcall}, 8'h01);
      exp_gcall = 1'b1;
      exp_rx.push_back(8'h06);
      write_byte(8'h06, a); check("t7_data_ack", {7'd0, a}, 8'h00);
      stop_c();
      check("t7_gcall_clear", {7'd0, gcall}, 8'h00);
      exp_gcall = 1'b0;
`else
      check("t7_gcall_nack", {7'd0, a}, 8'h01);
      write_byte(8'h06, a); check("t7_data_nack", {7'd0, a}, 8'h01);
      stop_c();
`endif
      end_checks("t7");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
